// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: arbitrates the register file's single write port between
// the pipeline write-back (absolute priority) and a long-latency (LL) unit.
// LL results wait in a DEPTH-entry FIFO and drain on idle WB slots. A busy
// scoreboard tracks outstanding LL destinations for decode hazard detection.
//
// Optional feature macro: RFARB_STARVE_EN (adds starvation counter + pipe_stall).
//
// Ports:
//   clk, n_rst                     clock, async active-low reset
//   wb_wr_en/id/data               pipeline write-back request
//   ll_valid/ll_ready/ll_rd/data   LL result handshake into the FIFO
//   issue_en/issue_rd              LL op issue, marks destination busy
//   rs1_id/rs2_id/rd_id -> hazard  decode hazard check against busy bits
//   rf_wr_en/id/data               register file write port (combinational)
//   fifo_count                     queued LL entries
//   pipe_stall                     starvation stall request (macro only)
module regfile_wr_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wb_wr_en,
  input  logic [4:0]              wb_wr_id,
  input  logic [XLEN-1:0]         wb_wr_data,
  input  logic                    ll_valid,
  output logic                    ll_ready,
  input  logic [4:0]              ll_rd,
  input  logic [XLEN-1:0]         ll_data,
  input  logic                    issue_en,
  input  logic [4:0]              issue_rd,
  input  logic [4:0]              rs1_id,
  input  logic [4:0]              rs2_id,
  input  logic [4:0]              rd_id,
  output logic                    hazard,
  output logic                    rf_wr_en,
  output logic [4:0]              rf_wr_id,
  output logic [XLEN-1:0]         rf_wr_data,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef RFARB_STARVE_EN
  ,
  output logic                    pipe_stall
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  // Elaboration-time parameter sanity check
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT == 0) begin : g_bad_param
    $error("regfile_wr_arbiter: DEPTH must be a power of 2 >= 2, STARVE_LIMIT > 0");
  end

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [4:0]      rd_mem_d   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     busy_q, busy_d;

  logic            wb_act;
  logic            empty;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign wb_act    = wb_wr_en & (wb_wr_id != 5'd0);
  assign empty     = (cnt_q == CW'(0));
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Ready from the registered count only; held low while in reset
  assign ll_ready   = n_rst & (cnt_q < CW'(DEPTH));
  assign push       = ll_valid & ll_ready & (ll_rd != 5'd0);
  assign fifo_count = cnt_q;
  assign hazard     = busy_q[rs1_id] | busy_q[rs2_id] | busy_q[rd_id];

  // Write-port grant: WB first, then FIFO head, else idle with zeroed bus
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_id   = 5'd0;
    rf_wr_data = '0;
    pop        = 1'b0;
    if (n_rst) begin
      if (wb_act) begin
        rf_wr_en   = 1'b1;
        rf_wr_id   = wb_wr_id;
        rf_wr_data = wb_wr_data;
      end else if (!empty) begin
        rf_wr_en   = 1'b1;
        rf_wr_id   = head_rd;
        rf_wr_data = head_data;
        pop        = 1'b1;
      end
    end
  end

  // FIFO and scoreboard next state; issue set is applied after the clear so it wins
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = CW'(cnt_q + CW'(push) - CW'(pop));
    busy_d     = busy_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = ll_rd;
      data_mem_d[wr_ptr_q] = ll_data;
      wr_ptr_d             = AW'(wr_ptr_q + AW'(1));
    end
    if (pop) begin
      rd_ptr_d        = AW'(rd_ptr_q + AW'(1));
      busy_d[head_rd] = 1'b0;
    end
    if (issue_en && issue_rd != 5'd0) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

`ifdef RFARB_STARVE_EN
  logic [SW-1:0] starve_q, starve_d;

  // Counts WB-blocked cycles of a waiting head; saturates at the limit
  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = SW'(0);
    end else if (!empty && wb_act && starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = SW'(starve_q + SW'(1));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign pipe_stall = (starve_q >= SW'(STARVE_LIMIT));
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed vectors, with a negedge monitor
// that checks every cycle against a scoreboard queue of expected LL writes
// and a reference busy-bit model.
module tb_regfile_wr_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            wb_wr_en;
  logic [4:0]      wb_wr_id;
  logic [XLEN-1:0] wb_wr_data;
  logic            ll_valid;
  logic            ll_ready;
  logic [4:0]      ll_rd;
  logic [XLEN-1:0] ll_data;
  logic            issue_en;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_id;
  logic [4:0]      rs2_id;
  logic [4:0]      rd_id;
  logic            hazard;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_id;
  logic [XLEN-1:0] rf_wr_data;
  logic [2:0]      fifo_count;
`ifdef RFARB_STARVE_EN
  logic            pipe_stall;
  int              m_starve;
`endif

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wb_wr_en   (wb_wr_en),
    .wb_wr_id   (wb_wr_id),
    .wb_wr_data (wb_wr_data),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_rd      (ll_rd),
    .ll_data    (ll_data),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .rd_id      (rd_id),
    .hazard     (hazard),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_id   (rf_wr_id),
    .rf_wr_data (rf_wr_data),
    .fifo_count (fifo_count)
`ifdef RFARB_STARVE_EN
    ,
    .pipe_stall (pipe_stall)
`endif
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ll_t;

  int          checks   = 0;
  int          failures = 0;
  ll_t         exp_ll[$];
  logic [31:0] m_busy;
  int          sz;
  logic        m_wb;
  logic        m_ready;
  ll_t         e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle comparison against the scoreboard and reference model
  always @(negedge clk) begin
    if (!n_rst) begin
      chk("rst_rf_wr_en",   64'(rf_wr_en),   64'd0);
      chk("rst_rf_wr_id",   64'(rf_wr_id),   64'd0);
      chk("rst_rf_wr_data", 64'(rf_wr_data), 64'd0);
      chk("rst_ll_ready",   64'(ll_ready),   64'd0);
      chk("rst_hazard",     64'(hazard),     64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      exp_ll.delete();
      m_busy = '0;
`ifdef RFARB_STARVE_EN
      chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
      m_starve = 0;
`endif
    end else begin
      sz      = exp_ll.size();
      m_wb    = wb_wr_en && (wb_wr_id != 5'd0);
      m_ready = (sz < int'(DEPTH));
      chk("mon_ll_ready",   64'(ll_ready),   64'(m_ready));
      chk("mon_fifo_count", 64'(fifo_count), 64'(sz));
      chk("mon_hazard",     64'(hazard),     64'(m_busy[rs1_id] | m_busy[rs2_id] | m_busy[rd_id]));
`ifdef RFARB_STARVE_EN
      chk("mon_pipe_stall", 64'(pipe_stall), 64'(m_starve >= 8));
      if (!m_wb && sz > 0) m_starve = 0;
      else if (sz > 0 && m_wb && m_starve < 8) m_starve++;
`endif
      if (m_wb) begin
        chk("wb_rf_wr_en",   64'(rf_wr_en),   64'd1);
        chk("wb_rf_wr_id",   64'(rf_wr_id),   64'(wb_wr_id));
        chk("wb_rf_wr_data", 64'(rf_wr_data), 64'(wb_wr_data));
      end else if (sz > 0) begin
        e = exp_ll.pop_front();
        chk("ll_rf_wr_en",   64'(rf_wr_en),   64'd1);
        chk("ll_rf_wr_id",   64'(rf_wr_id),   64'(e.rd));
        chk("ll_rf_wr_data", 64'(rf_wr_data), 64'(e.data));
        m_busy[e.rd] = 1'b0;
      end else begin
        chk("idle_rf_wr_en",   64'(rf_wr_en),   64'd0);
        chk("idle_rf_wr_id",   64'(rf_wr_id),   64'd0);
        chk("idle_rf_wr_data", 64'(rf_wr_data), 64'd0);
      end
      if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (ll_valid && m_ready && ll_rd != 5'd0) exp_ll.push_back('{rd: ll_rd, data: ll_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; wb_wr_en = 1'b1; wb_wr_id = 5'd5; wb_wr_data = 32'hDEAD;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = '0;
    issue_en = 1'b0; issue_rd = 5'd0;
    rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1; wb_wr_en = 1'b0;
    @(negedge clk);
    chk("release_ll_ready", 64'(ll_ready), 64'd1);

    // WB-only writes, including the r0 suppression
    tick();
    wb_wr_en = 1'b1; wb_wr_id = 5'd5; wb_wr_data = 32'h1234;
    @(negedge clk);
    chk("wb5_en",   64'(rf_wr_en),   64'd1);
    chk("wb5_id",   64'(rf_wr_id),   64'd5);
    chk("wb5_data", 64'(rf_wr_data), 64'h1234);
    tick();
    wb_wr_id = 5'd0;
    @(negedge clk);
    chk("wb0_en", 64'(rf_wr_en), 64'd0);

    // WB/LL conflict on r3 vs r7
    tick();
    wb_wr_en = 1'b0; issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    issue_en = 1'b0; rs1_id = 5'd7;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hAA;
    wb_wr_en = 1'b1; wb_wr_id = 5'd3; wb_wr_data = 32'h33;
    @(negedge clk);
    chk("conf_hazard_r7", 64'(hazard), 64'd1);
    tick();
    ll_valid = 1'b0; wb_wr_data = 32'h34;
    @(negedge clk);
    chk("conf_wb_id",  64'(rf_wr_id),   64'd3);
    chk("conf_count1", 64'(fifo_count), 64'd1);
    tick();
    wb_wr_en = 1'b0;
    @(negedge clk);
    chk("conf_ll_id",   64'(rf_wr_id),   64'd7);
    chk("conf_ll_data", 64'(rf_wr_data), 64'hAA);
    tick();
    @(negedge clk);
    chk("conf_busy7_clr", 64'(hazard), 64'd0);
    rs1_id = 5'd0;

    // FIFO full: five offers while WB holds the port
    tick();
    wb_wr_en = 1'b1; wb_wr_id = 5'd1; wb_wr_data = 32'h11;
    for (int i = 0; i < 5; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_data = 32'(32'h100 + i);
      tick();
    end
    wb_wr_en = 1'b0; ll_rd = 5'd15; ll_data = 32'h10F;
    @(negedge clk);
    chk("full_count",       64'(fifo_count), 64'd4);
    chk("full_ready_pop",   64'(ll_ready),   64'd0);
    chk("full_head_id",     64'(rf_wr_id),   64'd10);
    tick();
    @(negedge clk);
    chk("full_ready_after", 64'(ll_ready),   64'd1);
    chk("full_count_after", 64'(fifo_count), 64'd3);
    tick();
    ll_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("full_drained", 64'(fifo_count), 64'd0);

    // Scoreboard: RAW hazard and set-wins-over-clear
    tick();
    issue_en = 1'b1; issue_rd = 5'd9; rs1_id = 5'd9;
    tick();
    issue_en = 1'b0;
    wb_wr_en = 1'b1; wb_wr_id = 5'd2; wb_wr_data = 32'h22;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    @(negedge clk);
    chk("sb_raw_hazard", 64'(hazard), 64'd1);
    tick();
    ll_valid = 1'b0; wb_wr_en = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    chk("sb_pop_r9", 64'(rf_wr_id), 64'd9);
    tick();
    issue_en = 1'b0; rs1_id = 5'd0; rd_id = 5'd9;
    @(negedge clk);
    chk("sb_set_wins", 64'(hazard), 64'd1);
    tick();
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A;
    tick();
    ll_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sb_cleared", 64'(hazard), 64'd0);
    rd_id = 5'd0;

    // Reset with three entries queued and a busy bit outstanding
    tick();
    wb_wr_en = 1'b1; wb_wr_id = 5'd4; wb_wr_data = 32'h44;
    issue_en = 1'b1; issue_rd = 5'd23; rd_id = 5'd23;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(20 + i); ll_data = 32'(32'h200 + i);
      tick();
      issue_en = 1'b0;
    end
    ll_valid = 1'b0;
    @(negedge clk);
    chk("mid_count3", 64'(fifo_count), 64'd3);
    chk("mid_hazard", 64'(hazard),     64'd1);
    #2 n_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count",  64'(fifo_count), 64'd0);
    chk("mid_rst_en",     64'(rf_wr_en),   64'd0);
    chk("mid_rst_hazard", 64'(hazard),     64'd0);
    chk("mid_rst_ready",  64'(ll_ready),   64'd0);
    tick();
    n_rst = 1'b1; wb_wr_en = 1'b0; rd_id = 5'd0;
    @(negedge clk);
    chk("mid_rel_ready", 64'(ll_ready), 64'd1);
    chk("mid_rel_en",    64'(rf_wr_en), 64'd0);

`ifdef RFARB_STARVE_EN
    // Starvation: WB blocks a queued head until pipe_stall, then a bubble drains it
    tick();
    wb_wr_en = 1'b1; wb_wr_id = 5'd1; wb_wr_data = 32'h55;
    ll_valid = 1'b1; ll_rd = 5'd6; ll_data = 32'h66;
    tick();
    ll_valid = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("starve_stall", 64'(pipe_stall), 64'd1);
    tick();
    wb_wr_en = 1'b0;
    tick();
    @(negedge clk);
    chk("starve_clear", 64'(pipe_stall), 64'd0);
`endif

    repeat (3) tick();
    chk("sb_queue_empty", 64'(exp_ll.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
